// File: rtl/upsample.sv
// Integer-factor upsampler from a low-rate sample stream to the 48 kHz base rate.
//
// The factor is N = 2^Nlog2 (N = 1, 2, 4 or 8). Each low-rate sample opens a segment
// of N base-rate ticks. The first tick of a segment carries the strobe.
// Three output styles are supported:
//   - zero-stuff: the sample, then N-1 zeros.
//   - sample-hold: the sample is repeated N times.
//   - linear: interpolates from the previous sample toward the new one. In this mode the
//     output runs one low-rate period behind the input.
// A missing strobe (underrun) or an early strobe sets the sticky sync_err flag.
//
// Ports:
//   clock      in   master clock, rising edge
//   reset      in   synchronous, active-high
//   enclk      in   base-rate tick, one-cycle pulse
//   Nlog2[1:0] in   log2 of the interpolation factor, latched on strobe ticks
//   mode[1:0]  in   00 zero-stuff, 01 sample-hold, 1x linear
//   datain     in   signed 18-bit low-rate sample
//   endatain   in   low-rate strobe, qualified by enclk
//   dataout    out  signed 18-bit base-rate sample, registered
//   endataout  out  one-cycle pulse in the cycle after each tick
//   sync_err   out  sticky strobe-cadence error
module upsample (
  input  logic               clock,
  input  logic               reset,
  input  logic               enclk,
  input  logic [1:0]         Nlog2,
  input  logic [1:0]         mode,
  input  logic signed [17:0] datain,
  input  logic               endatain,
  output logic signed [17:0] dataout,
  output logic               endataout,
  output logic               sync_err
);

  logic signed [17:0] cur_q, cur_d;
  logic signed [17:0] dout_q, dout_d;
  logic signed [18:0] diff_q, diff_d;
  logic signed [20:0] acc_q, acc_d;
  logic [3:0]         ph_q, ph_d;
  logic [1:0]         l_q, l_d;
  logic               err_q, err_d;
  logic               en_q, en_d;

  logic               strobe;
  logic [3:0]         span;
  logic signed [18:0] new_diff;
  logic [20:0]        cur_sh;
  logic signed [20:0] acc_new;
  logic signed [20:0] acc_step;
  logic signed [17:0] lin_out;

  always_comb begin
    strobe   = enclk & endatain;
    span     = 4'd1 << l_q;
    new_diff = {datain[17], datain} - {cur_q[17], cur_q};
    // The segment's first interpolated point is (cur_old*N + diff) / N.
    cur_sh   = {{3{cur_q[17]}}, cur_q} << Nlog2;
    acc_new  = cur_sh + {{2{new_diff[18]}}, new_diff};
    acc_step = acc_q + {{2{diff_q[18]}}, diff_q};
    // Taking bits [L+17:L] gives the floor of acc >>> L.
    // acc stays between cur_old<<<L and cur<<<L, so the result fits in 18 bits.
    lin_out  = acc_q[{3'b000, l_q} +: 18];
  end

  always_comb begin
    cur_d  = cur_q;
    dout_d = dout_q;
    diff_d = diff_q;
    acc_d  = acc_q;
    ph_d   = ph_q;
    l_d    = l_q;
    err_d  = err_q;
    en_d   = enclk;

    if (enclk) begin
      if (strobe) begin
        // ph == 0 is the first strobe after reset. ph == span is the on-time strobe.
        if ((ph_q != 4'd0) && (ph_q != span)) begin
          err_d = 1'b1;
        end
        cur_d  = datain;
        l_d    = Nlog2;
        ph_d   = 4'd1;
        diff_d = new_diff;
        acc_d  = acc_new;
        dout_d = mode[1] ? cur_q : datain;
      end else if (ph_q == 4'd0) begin
        // No sample has been accepted yet.
        dout_d = '0;
      end else if (ph_q < span) begin
        ph_d  = ph_q + 4'd1;
        // acc advances in every mode, so switching to linear mid-stream is coherent.
        acc_d = acc_step;
        case (mode)
          2'b00:   dout_d = '0;
          2'b01:   dout_d = cur_q;
          default: dout_d = lin_out;
        endcase
      end else begin
        // Underrun: the segment is exhausted and no strobe arrived.
        // ph and acc hold, so the output repeats cur.
        dout_d = cur_q;
        err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_q  <= '0;
      dout_q <= '0;
      diff_q <= '0;
      acc_q  <= '0;
      ph_q   <= '0;
      l_q    <= '0;
      err_q  <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      dout_q <= dout_d;
      diff_q <= diff_d;
      acc_q  <= acc_d;
      ph_q   <= ph_d;
      l_q    <= l_d;
      err_q  <= err_d;
      en_q   <= en_d;
    end
  end

  assign dataout   = dout_q;
  assign endataout = en_q;
  assign sync_err  = err_q;

endmodule

// File: tb/tb_upsample.sv
// Directed bench for upsample.
// Each task drives one scenario and checks against hand-computed values.
module tb_upsample;

  logic               clock = 1'b0;
  logic               reset;
  logic               enclk;
  logic [1:0]         Nlog2;
  logic [1:0]         mode;
  logic signed [17:0] datain;
  logic               endatain;
  logic signed [17:0] dataout;
  logic               endataout;
  logic               sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [17:0] t_dout;
  logic               t_en;
  logic               t_en_idle;

  upsample dut (
    .clock    (clock),
    .reset    (reset),
    .enclk    (enclk),
    .Nlog2    (Nlog2),
    .mode     (mode),
    .datain   (datain),
    .endatain (endatain),
    .dataout  (dataout),
    .endataout(endataout),
    .sync_err (sync_err)
  );

  always #5 clock = ~clock;

  // One tick, then one idle cycle. Captures dataout and endataout after the tick,
  // and endataout after the idle cycle.
  task automatic do_tick(input logic stb, input logic signed [17:0] d);
    enclk = 1'b1; endatain = stb; datain = d;
    @(posedge clock); #1;
    t_dout = dataout; t_en = endataout;
    enclk = 1'b0; endatain = 1'b0;
    @(posedge clock); #1;
    t_en_idle = endataout;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    mode = 2'b01; Nlog2 = 2'd1;
    do_reset();
    do_tick(1'b1, 18'sd123);
    do_tick(1'b1, 18'sd124);  // early strobe sets sync_err
    if (sync_err !== 1'b1) begin
      $display("FAIL reset_pre_err got=%b exp=1", sync_err); n_fail++;
    end
    n_checks++;
    // Reset dominates a simultaneous strobe tick.
    reset = 1'b1; enclk = 1'b1; endatain = 1'b1; datain = 18'sd777;
    @(posedge clock); #1;
    reset = 1'b0; enclk = 1'b0; endatain = 1'b0;
    if (dataout !== 18'sd0) begin
      $display("FAIL reset_dataout got=%0d exp=0", dataout); n_fail++;
    end
    n_checks++;
    if (endataout !== 1'b0) begin
      $display("FAIL reset_endataout got=%b exp=0", endataout); n_fail++;
    end
    n_checks++;
    if (sync_err !== 1'b0) begin
      $display("FAIL reset_sync_err got=%b exp=0", sync_err); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_linear();
    int exp_l[12] = '{0, 0, 0, 0, 0, 100, 200, 300, 400, 400, 400, 400};
    logic signed [17:0] d;
    mode = 2'b10; Nlog2 = 2'd2;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      d = (i < 4) ? 18'sd0 : 18'sd400;
      do_tick((i % 4) == 0, d);
      if (t_dout !== 18'(exp_l[i])) begin
        $display("FAIL linear[%0d] dataout got=%0d exp=%0d", i, t_dout, exp_l[i]); n_fail++;
      end
      n_checks++;
      if (t_en !== 1'b1 || t_en_idle !== 1'b0) begin
        $display("FAIL linear_en[%0d] got=%b/%b exp=1/0", i, t_en, t_en_idle); n_fail++;
      end
      n_checks++;
    end
    if (sync_err !== 1'b0) begin
      $display("FAIL linear_sync_err got=%b exp=0", sync_err); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_floor();
    int exp_f[3] = '{0, -2, -3};
    logic stb_f[3] = '{1'b1, 1'b0, 1'b1};
    mode = 2'b10; Nlog2 = 2'd1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_tick(stb_f[i], -18'sd3);
      if (t_dout !== 18'(exp_f[i])) begin
        $display("FAIL floor[%0d] dataout got=%0d exp=%0d", i, t_dout, exp_f[i]); n_fail++;
      end
      n_checks++;
    end
    if (sync_err !== 1'b0) begin
      $display("FAIL floor_sync_err got=%b exp=0", sync_err); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_hold_zero();
    int exp_h[8] = '{1000, 1000, 1000, 1000, 1000, 0, 0, 0};
    Nlog2 = 2'd2; mode = 2'b01;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) mode = 2'b00;
      do_tick((i % 4) == 0, 18'sd1000);
      if (t_dout !== 18'(exp_h[i])) begin
        $display("FAIL hold_zero[%0d] dataout got=%0d exp=%0d", i, t_dout, exp_h[i]); n_fail++;
      end
      n_checks++;
    end
    if (sync_err !== 1'b0) begin
      $display("FAIL hold_zero_sync_err got=%b exp=0", sync_err); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_underrun();
    int exp_u[7] = '{0, 125, 250, 375, 500, 500, 500};
    mode = 2'b10; Nlog2 = 2'd2;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      do_tick(i == 0, 18'sd500);
      if (t_dout !== 18'(exp_u[i])) begin
        $display("FAIL underrun[%0d] dataout got=%0d exp=%0d", i, t_dout, exp_u[i]); n_fail++;
      end
      n_checks++;
      if (sync_err !== (i >= 4)) begin
        $display("FAIL underrun_err[%0d] got=%b exp=%b", i, sync_err, i >= 4); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_early();
    mode = 2'b01; Nlog2 = 2'd3;
    do_reset();
    do_tick(1'b1, 18'sd100);
    if (sync_err !== 1'b0) begin
      $display("FAIL early_first got=%b exp=0", sync_err); n_fail++;
    end
    n_checks++;
    do_tick(1'b0, 18'sd0);
    do_tick(1'b0, 18'sd0);
    do_tick(1'b1, 18'sd200);
    if (sync_err !== 1'b1 || t_dout !== 18'sd200) begin
      $display("FAIL early_resync got=%b/%0d exp=1/200", sync_err, t_dout); n_fail++;
    end
    n_checks++;
    do_tick(1'b0, 18'sd0);
    if (t_dout !== 18'sd200) begin
      $display("FAIL early_after got=%0d exp=200", t_dout); n_fail++;
    end
    n_checks++;
    do_reset();
    if (dataout !== 18'sd0 || endataout !== 1'b0 || sync_err !== 1'b0) begin
      $display("FAIL early_reset got=%0d/%b/%b exp=0/0/0", dataout, endataout, sync_err);
      n_fail++;
    end
    n_checks++;
    do_tick(1'b1, 18'sd300);
    if (sync_err !== 1'b0 || t_dout !== 18'sd300) begin
      $display("FAIL early_restart got=%b/%0d exp=0/300", sync_err, t_dout); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_ignored_strobe();
    mode = 2'b01; Nlog2 = 2'd1;
    do_reset();
    do_tick(1'b1, 18'sd50);
    endatain = 1'b1; datain = 18'sd999;
    @(posedge clock); #1;
    endatain = 1'b0;
    if (endataout !== 1'b0 || dataout !== 18'sd50) begin
      $display("FAIL ignored_strobe got=%b/%0d exp=0/50", endataout, dataout); n_fail++;
    end
    n_checks++;
    do_tick(1'b0, 18'sd0);
    if (t_dout !== 18'sd50) begin
      $display("FAIL ignored_hold got=%0d exp=50", t_dout); n_fail++;
    end
    n_checks++;
    do_tick(1'b1, 18'sd60);
    if (sync_err !== 1'b0 || t_dout !== 18'sd60) begin
      $display("FAIL ignored_cadence got=%b/%0d exp=0/60", sync_err, t_dout); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_pre_strobe();
    mode = 2'b01; Nlog2 = 2'd2;
    do_reset();
    do_tick(1'b0, 18'sd7);
    do_tick(1'b0, 18'sd7);
    if (t_dout !== 18'sd0) begin
      $display("FAIL pre_strobe_out got=%0d exp=0", t_dout); n_fail++;
    end
    n_checks++;
    do_tick(1'b1, 18'sd10);
    if (sync_err !== 1'b0 || t_dout !== 18'sd10) begin
      $display("FAIL pre_strobe_first got=%b/%0d exp=0/10", sync_err, t_dout); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_n1();
    int exp_n[3] = '{0, 10, 20};
    mode = 2'b10; Nlog2 = 2'd0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b1, 18'(10 * (i + 1)));
      if (t_dout !== 18'(exp_n[i])) begin
        $display("FAIL n1[%0d] dataout got=%0d exp=%0d", i, t_dout, exp_n[i]); n_fail++;
      end
      n_checks++;
    end
    if (sync_err !== 1'b0) begin
      $display("FAIL n1_sync_err got=%b exp=0", sync_err); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_nlog2_change();
    mode = 2'b01; Nlog2 = 2'd1;
    do_reset();
    do_tick(1'b1, 18'sd5);
    Nlog2 = 2'd2;  // must not shorten or lengthen the current segment
    do_tick(1'b0, 18'sd0);
    do_tick(1'b1, 18'sd6);
    if (sync_err !== 1'b0) begin
      $display("FAIL nlog2_old_seg got=%b exp=0", sync_err); n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 3; i++) do_tick(1'b0, 18'sd0);
    do_tick(1'b1, 18'sd7);
    if (sync_err !== 1'b0 || t_dout !== 18'sd7) begin
      $display("FAIL nlog2_new_seg got=%b/%0d exp=0/7", sync_err, t_dout); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_mode_switch();
    mode = 2'b01; Nlog2 = 2'd2;
    do_reset();
    do_tick(1'b1, 18'sd0);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 18'sd0);
    do_tick(1'b1, 18'sd400);
    if (t_dout !== 18'sd400) begin
      $display("FAIL mode_hold got=%0d exp=400", t_dout); n_fail++;
    end
    n_checks++;
    mode = 2'b10;
    do_tick(1'b0, 18'sd0);
    if (t_dout !== 18'sd100) begin
      $display("FAIL mode_lin1 got=%0d exp=100", t_dout); n_fail++;
    end
    n_checks++;
    mode = 2'b11;
    do_tick(1'b0, 18'sd0);
    if (t_dout !== 18'sd200) begin
      $display("FAIL mode_lin2 got=%0d exp=200", t_dout); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    reset = 1'b1; enclk = 1'b0; endatain = 1'b0; datain = '0; Nlog2 = '0; mode = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_linear();
    test_floor();
    test_hold_zero();
    test_underrun();
    test_early();
    test_ignored_strobe();
    test_pre_strobe();
    test_n1();
    test_nlog2_change();
    test_mode_switch();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/upsample.md
UPSAMPLE -- requirements
Module: upsample

Interface
REQ-001 clock  input  1  master clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high.
REQ-003 enclk  input  1  base-rate (48 kHz) tick, one-cycle pulse.
REQ-004 Nlog2  input  2  interpolation factor N = 2^Nlog2 (1, 2, 4, 8); latched only at segment start.
REQ-005 mode  input  2  00 zero-stuff, 01 sample-hold, 10 linear, 11 treated as linear; sampled every tick.
REQ-006 datain  input  18  signed low-rate sample.
REQ-007 endatain  input  1  low-rate strobe; counted only when enclk=1, ignored otherwise.
REQ-008 dataout  output  18  signed base-rate sample, registered.
REQ-009 endataout  output  1  one-cycle pulse marking a new dataout.
REQ-010 sync_err  output  1  sticky strobe-cadence error flag.

Function
REQ-011 Definitions: tick = enclk=1; strobe tick = tick with endatain=1.
REQ-012 Internal state: cur (18b, last accepted sample), diff (19b signed), acc (21b signed), ph (4b), L (2b latched Nlog2).
REQ-013 endataout SHALL be 1 in the cycle after each tick, else 0. dataout is valid in the same cycle and held between ticks.
REQ-014 Strobe tick, all modes:
  - cur <= datain; L <= Nlog2; ph <= 1
  - diff <= sext19(datain) - sext19(cur_old)
  - acc <= (sext21(cur_old) <<< Nlog2) + sext21(datain - cur_old)
REQ-015 Strobe tick dataout:
  - linear: cur_old (one low-rate period of latency)
  - hold, zero-stuff: datain
REQ-016 Non-strobe tick with ph < 2^L, linear: dataout <= acc >>> L (arithmetic shift, floor); acc <= acc + sext21(diff); ph <= ph+1.
REQ-017 Non-strobe tick with ph < 2^L, other modes: hold -> dataout <= cur; zero-stuff -> dataout <= 0. ph increments.
REQ-018 acc SHALL stay between cur_old<<<L and cur<<<L, so 21 bits cannot overflow. No saturation logic.
REQ-019 Underrun: non-strobe tick with ph == 2^L (strobe missing).
  - dataout <= cur in every mode; sync_err <= 1
  - ph and acc hold, so repeated underruns keep outputting cur
REQ-020 Early strobe: strobe tick with ph != 0 and ph != 2^L.
  - sync_err <= 1
  - sample accepted exactly as REQ-014/015 (resync)
REQ-021 First strobe after reset (ph == 0) SHALL NOT flag an error.
REQ-022 Non-strobe ticks before the first strobe SHALL output 0 and leave ph at 0.
REQ-023 N=1: every tick is a strobe tick and ph stays at 1; valid cadence, no error.
REQ-024 A Nlog2 change mid-segment SHALL take effect only at the next strobe tick.
REQ-025 A mode change takes effect at the next tick. acc/diff SHALL keep updating per REQ-016 in all modes so that a switch to linear is coherent.
REQ-026 Cycles with enclk=0 SHALL change no state except endataout <= 0.

Reset
REQ-027 Reset cycle SHALL clear:
  - dataout, cur, diff, acc, ph, L to 0
  - endataout, sync_err to 0
REQ-028 Reset SHALL dominate enclk/endatain in the same cycle. Reset mid-segment discards the segment; the next strobe is treated as first (REQ-021).

Verification
REQ-029 Linear, Nlog2=2, strobes every 4 ticks with datain 0, 400, 400 -> dataout per tick 0,0,0,0, 0,100,200,300, 400,400,400,400; sync_err=0.
REQ-030 Linear, Nlog2=1, cur=0, strobe datain=-3 -> dataout 0 then -2 (floor); next strobe datain=-3 -> -3.
REQ-031 Hold and zero-stuff, Nlog2=2, strobe datain=1000 -> hold 1000,1000,1000,1000; zero-stuff 1000,0,0,0.
REQ-032 Nlog2=2, strobe omitted at 4th tick after a strobe with datain=500 -> dataout=500 on every following tick; sync_err=1 until reset.
REQ-033 Nlog2=3, strobe after only 3 ticks -> sync_err=1, new sample accepted, output restarts at phase 0; reset -> all outputs 0, sync_err=0, next strobe no error.
REQ-034 Cadence checks:
  - endatain=1 with enclk=0 -> no state change
  - endataout pulses exactly once per tick, one cycle later
